// File: rtl/uart_byte_to_word_rx.sv
// UART 8N1 receiver with optional packing of four bytes into a 32-bit word
// (most significant byte first). A partial word is dropped after a long idle
// gap, a mode change, a frame error or an abort.
module uart_byte_to_word_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        i_mode_select,
  input  logic        i_serial,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  output logic [31:0] o_word,
  output logic        o_word_valid,
  output logic        o_frame_error,
  output logic        o_busy
);

  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TO_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  logic              meta_q, rx_q;
  logic              rx_s;
  logic              mode_q;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        byte_idx_q, byte_idx_d, idx_fsm_s;
  logic [31:0]       word_acc_q, word_acc_d;
  logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [7:0]        byte_q, byte_d;
  logic [31:0]       word_q, word_d;
  logic              byte_valid_q, byte_valid_d;
  logic              word_valid_q, word_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;
  logic              idx_clear_s;

  assign rx_s = rx_q;

  // Two-flop synchronizer for the asynchronous serial line, idle high.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b1;
      rx_q   <= 1'b1;
    end else begin
      meta_q <= i_serial;
      rx_q   <= meta_q;
    end
  end

  // Next-state logic: frame FSM, bit sampling, word packing and idle timeout.
  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    idx_fsm_s    = byte_idx_q;
    word_acc_d   = word_acc_q;
    idle_cnt_d   = {TO_W{1'b0}};
    byte_d       = byte_q;
    word_d       = word_q;
    byte_valid_d = 1'b0;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (!enable) begin
      state_d   = IDLE;
      clk_cnt_d = {CNT_W{1'b0}};
      bit_cnt_d = 3'd0;
      idx_fsm_s = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          clk_cnt_d = {CNT_W{1'b0}};
          bit_cnt_d = 3'd0;
          if (!rx_s) begin
            state_d = START;
          end else begin
            state_d = IDLE;
          end
          // Partial word ages out after a long quiet line.
          if (byte_idx_q != 2'd0) begin
            if (idle_cnt_q >= TO_MAX) begin
              idx_fsm_s  = 2'd0;
              idle_cnt_d = {TO_W{1'b0}};
            end else begin
              idle_cnt_d = idle_cnt_q + TO_W'(1);
            end
          end else begin
            idle_cnt_d = {TO_W{1'b0}};
          end
        end
        START: begin
          if (clk_cnt_q == CNT_MID) begin
            clk_cnt_d = {CNT_W{1'b0}};
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
            end
          end else begin
            clk_cnt_d = clk_cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_d = {CNT_W{1'b0}};
            shift_d   = {rx_s, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = 3'd0;
              state_d   = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            clk_cnt_d = clk_cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_d = {CNT_W{1'b0}};
            state_d   = IDLE;
            if (rx_s) begin
              byte_d       = shift_q;
              byte_valid_d = 1'b1;
              if (!i_mode_select) begin
                word_acc_d = {word_acc_q[23:0], shift_q};
                if (byte_idx_q == 2'd3) begin
                  word_d       = {word_acc_q[23:0], shift_q};
                  word_valid_d = 1'b1;
                  idx_fsm_s    = 2'd0;
                end else begin
                  idx_fsm_s = byte_idx_q + 2'd1;
                end
              end else begin
                idx_fsm_s = 2'd0;
              end
            end else begin
              frame_err_d = 1'b1;
              idx_fsm_s   = 2'd0;
            end
          end else begin
            clk_cnt_d = clk_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          clk_cnt_d = {CNT_W{1'b0}};
          bit_cnt_d = 3'd0;
          idx_fsm_s = 2'd0;
        end
      endcase
    end

    // Byte mode keeps the index parked; a mode flip drops any partial word.
    idx_clear_s = i_mode_select || (i_mode_select != mode_q);
    byte_idx_d  = idx_clear_s ? 2'd0 : idx_fsm_s;
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset clears everything including held data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      clk_cnt_q    <= {CNT_W{1'b0}};
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_idx_q   <= 2'd0;
      word_acc_q   <= 32'h0000_0000;
      idle_cnt_q   <= {TO_W{1'b0}};
      mode_q       <= 1'b0;
      byte_q       <= 8'h00;
      word_q       <= 32'h0000_0000;
      byte_valid_q <= 1'b0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_idx_q   <= byte_idx_d;
      word_acc_q   <= word_acc_d;
      idle_cnt_q   <= idle_cnt_d;
      mode_q       <= i_mode_select;
      byte_q       <= byte_d;
      word_q       <= word_d;
      byte_valid_q <= byte_valid_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign o_byte        = byte_q;
  assign o_byte_valid  = byte_valid_q;
  assign o_word        = word_q;
  assign o_word_valid  = word_valid_q;
  assign o_frame_error = frame_err_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_uart_byte_to_word_rx.sv
// Directed bench for uart_byte_to_word_rx: a vector table of single frames
// plus hand-written glitch, timeout, enable-abort and reset-abort sequences.
module tb_uart_byte_to_word_rx;
  localparam int CPB = 8;
  localparam int TOB = 20;

  logic        clock = 1'b0;
  logic        reset, enable, i_mode_select, i_serial;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic [31:0] o_word;
  logic        o_word_valid, o_frame_error, o_busy;

  uart_byte_to_word_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clock(clock), .reset(reset), .enable(enable), .i_mode_select(i_mode_select),
    .i_serial(i_serial), .o_byte(o_byte), .o_byte_valid(o_byte_valid),
    .o_word(o_word), .o_word_valid(o_word_valid), .o_frame_error(o_frame_error),
    .o_busy(o_busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int bv_total = 0, wv_total = 0, fe_total = 0, wv_alone = 0;

  // Pulse counters sampled on the falling edge.
  always @(negedge clock) begin
    if (o_byte_valid) bv_total <= bv_total + 1;
    if (o_word_valid) wv_total <= wv_total + 1;
    if (o_frame_error) fe_total <= fe_total + 1;
    if (o_word_valid && !o_byte_valid) wv_alone <= wv_alone + 1;
  end

  typedef struct {
    logic        mode;
    logic [7:0]  data;
    logic        stop;
    int          n_bv;
    int          n_fe;
    int          n_wv;
    logic [7:0]  exp_byte;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bit_time(input logic b);
    i_serial = b;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge clock);
    #1;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time(stop);
    i_serial = 1'b1;
    repeat (2 * CPB) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, w0, f0;
    logic saw_busy, returned;

    vecs[0] = '{1'b0, 8'h00, 1'b1, 1, 0, 0, 8'h00, 32'h0000_0000};
    vecs[1] = '{1'b0, 8'hff, 1'b1, 1, 0, 0, 8'hff, 32'h0000_0000};
    vecs[2] = '{1'b0, 8'h90, 1'b1, 1, 0, 0, 8'h90, 32'h0000_0000};
    vecs[3] = '{1'b0, 8'haf, 1'b1, 1, 0, 1, 8'haf, 32'h00ff_90af};
    vecs[4] = '{1'b1, 8'hcd, 1'b1, 1, 0, 0, 8'hcd, 32'h00ff_90af};
    vecs[5] = '{1'b0, 8'h55, 1'b0, 0, 1, 0, 8'hcd, 32'h00ff_90af};
    vecs[6] = '{1'b0, 8'h11, 1'b1, 1, 0, 0, 8'h11, 32'h00ff_90af};
    vecs[7] = '{1'b0, 8'h22, 1'b1, 1, 0, 0, 8'h22, 32'h00ff_90af};
    vecs[8] = '{1'b0, 8'h33, 1'b1, 1, 0, 0, 8'h33, 32'h00ff_90af};
    vecs[9] = '{1'b0, 8'h44, 1'b1, 1, 0, 1, 8'h44, 32'h1122_3344};

    reset = 1'b1; enable = 1'b1; i_mode_select = 1'b0; i_serial = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_byte", {24'h0, o_byte}, 32'h0);
    check("rst_word", o_word, 32'h0);
    check("rst_bv", {31'h0, o_byte_valid}, 32'h0);
    check("rst_wv", {31'h0, o_word_valid}, 32'h0);
    check("rst_fe", {31'h0, o_frame_error}, 32'h0);
    check("rst_busy", {31'h0, o_busy}, 32'h0);

    // Table: word packing, byte mode, frame error then recovery.
    for (int v = 0; v < 10; v++) begin
      b0 = bv_total; w0 = wv_total; f0 = fe_total;
      i_mode_select = vecs[v].mode;
      send_frame(vecs[v].data, vecs[v].stop);
      check($sformatf("v%0d_bv", v), 32'(bv_total - b0), 32'(vecs[v].n_bv));
      check($sformatf("v%0d_fe", v), 32'(fe_total - f0), 32'(vecs[v].n_fe));
      check($sformatf("v%0d_wv", v), 32'(wv_total - w0), 32'(vecs[v].n_wv));
      check($sformatf("v%0d_byte", v), {24'h0, o_byte}, {24'h0, vecs[v].exp_byte});
      check($sformatf("v%0d_word", v), o_word, vecs[v].exp_word);
    end

    // Short low glitch on an idle line.
    b0 = bv_total; f0 = fe_total;
    saw_busy = 1'b0; returned = 1'b0;
    @(posedge clock);
    #1 i_serial = 1'b0;
    repeat (3) @(posedge clock);
    #1 i_serial = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (o_busy) saw_busy = 1'b1;
      else if (saw_busy) begin
        returned = 1'b1;
        break;
      end
    end
    check("glitch_busy_seen", {31'h0, saw_busy}, 32'h1);
    check("glitch_busy_clear", {31'h0, returned}, 32'h1);
    repeat (2 * CPB) @(negedge clock);
    check("glitch_bv", 32'(bv_total - b0), 32'h0);
    check("glitch_fe", 32'(fe_total - f0), 32'h0);

    // Partial word discarded by the idle timeout.
    w0 = wv_total;
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    repeat (200) @(negedge clock);
    check("to_no_word", 32'(wv_total - w0), 32'h0);
    send_frame(8'ha1, 1'b1);
    send_frame(8'hb2, 1'b1);
    send_frame(8'hc3, 1'b1);
    send_frame(8'hd4, 1'b1);
    check("to_wv", 32'(wv_total - w0), 32'h1);
    check("to_word", o_word, 32'ha1b2_c3d4);

    // Enable dropped during data bit 4 after two bytes of a word.
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    b0 = bv_total; w0 = wv_total; f0 = fe_total;
    @(posedge clock);
    #1;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(i[0]);
    i_serial = 1'b0;
    repeat (CPB / 2) @(posedge clock);
    #1 enable = 1'b0;
    i_serial = 1'b1;
    repeat (2) @(negedge clock);
    check("abort_busy", {31'h0, o_busy}, 32'h0);
    repeat (3 * CPB) @(negedge clock);
    enable = 1'b1;
    repeat (CPB) @(negedge clock);
    check("abort_bv", 32'(bv_total - b0), 32'h0);
    check("abort_fe", 32'(fe_total - f0), 32'h0);
    check("abort_byte_held", {24'h0, o_byte}, 32'h02);
    check("abort_word_held", o_word, 32'ha1b2_c3d4);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    send_frame(8'h56, 1'b1);
    send_frame(8'h78, 1'b1);
    check("abort_wv", 32'(wv_total - w0), 32'h1);
    check("abort_word", o_word, 32'h1234_5678);

    // Reset in the middle of a frame.
    @(posedge clock);
    #1;
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(1'b0);
    reset = 1'b1;
    i_serial = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("mrst_byte", {24'h0, o_byte}, 32'h0);
    check("mrst_word", o_word, 32'h0);
    check("mrst_bv", {31'h0, o_byte_valid}, 32'h0);
    check("mrst_wv", {31'h0, o_word_valid}, 32'h0);
    check("mrst_fe", {31'h0, o_frame_error}, 32'h0);
    check("mrst_busy", {31'h0, o_busy}, 32'h0);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clock);
    check("word_without_byte", 32'(wv_alone), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
